// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and helpers for the matrix-keypad scanner.
//
// Contents:
//   keypad_evt_t   - event record {press, row, col}. Fields are sized for the
//                    largest supported keypad (16x16). The scanner packs the
//                    fields down to its own RW/CW widths.
//   idx_w/rw_f/cw_f - index widths, max(1, clog2(n)).
//   cnt_w          - debounce counter width, clog2(DEBOUNCE_SCANS+1).
//   scan_div_ok    - SCAN_DIV must leave room to evaluate every column of a
//                    slot (SCAN_DIV >= COLS+1, and at least 4).
//   is_pow2        - FIFO depth check.
package keypad_pkg;

    localparam int EVT_ROW_W = 4;
    localparam int EVT_COL_W = 4;

    typedef struct packed {
        logic                 press;
        logic [EVT_ROW_W-1:0] row;
        logic [EVT_COL_W-1:0] col;
    } keypad_evt_t;

    function automatic int idx_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    function automatic int rw_f(input int rows);
        return idx_w(rows);
    endfunction

    function automatic int cw_f(input int cols);
        return idx_w(cols);
    endfunction

    function automatic int cnt_w(input int debounce_scans);
        return $clog2(debounce_scans + 1);
    endfunction

    function automatic bit scan_div_ok(input int scan_div, input int cols);
        return (scan_div >= cols + 1) && (scan_div >= 4);
    endfunction

    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/keypad_evt_fifo.sv
// keypad_evt_fifo: synchronous FIFO holding keypad events.
//
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset (empties FIFO)
//   wr_en, wr_data    - push request; accepted when not full, or when full
//                       and a pop happens in the same cycle
//   full              - FIFO holds DEPTH entries
//   rd_en             - pop request; honoured when not empty
//   rd_data           - head entry, forced to 0 while empty
//   empty             - FIFO holds no entries
module keypad_evt_fifo
    import keypad_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);

    localparam int AW = idx_w(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             wr_ok;
    logic             rd_ok;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == '0);

    // A pop frees the slot the push needs, so push-while-full is legal then.
    assign wr_ok = wr_en && (!full || rd_en);
    assign rd_ok = rd_en && !empty;

    always_comb begin
        wr_ptr_d = wr_ok ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = rd_ok ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; the empty mask keeps stale entries invisible.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: ROWS x COLS matrix-keypad scanner with debounce and an
// event FIFO.
//
// Optional feature macro: KEYPAD_RELEASE_EVENTS_EN
//   defined     - both press and release events are queued
//   not defined - only press events are queued; releases commit silently
//
// Ports:
//   clk        - single clock
//   rst_n      - asynchronous active-low reset
//   row_oe     - one-hot row drive enable (pin pulled to 0 when set), 0 in reset
//   row_in     - row pad readback (asynchronous)
//   col_n      - column pins, active-low pressed on the driven row (asynchronous)
//   evt_valid  - an event is at the FIFO head
//   evt_ready  - consumer accepts the head event
//   evt_code   - head event {press, row, col}
//   error      - sticky row-contention flag
//   err_clr    - synchronous clear of error (a simultaneous set wins)
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int ROWS           = 4,
    parameter int COLS           = 3,
    parameter int SCAN_DIV       = 64,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    output logic [ROWS-1:0]                  row_oe,
    input  logic [ROWS-1:0]                  row_in,
    input  logic [COLS-1:0]                  col_n,
    output logic                             evt_valid,
    input  logic                             evt_ready,
    output logic [rw_f(ROWS)+cw_f(COLS):0]   evt_code,
    output logic                             error,
    input  logic                             err_clr
);

    localparam int RW    = rw_f(ROWS);
    localparam int CW    = cw_f(COLS);
    localparam int EW    = 1 + RW + CW;
    localparam int KEYS  = ROWS * COLS;
    localparam int KW    = idx_w(KEYS);
    localparam int CNT_W = cnt_w(DEBOUNCE_SCANS);
    localparam int DIV_W = $clog2(SCAN_DIV);

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0] EVAL_FIRST = DIV_W'(1);
    localparam logic [DIV_W-1:0] EVAL_LAST  = DIV_W'(COLS);
    localparam logic [DIV_W-1:0] CHK_FIRST  = DIV_W'(2);
    localparam logic [RW-1:0]    ROW_LAST   = RW'(ROWS - 1);
    localparam logic [CNT_W-1:0] DEB_MAX    = CNT_W'(DEBOUNCE_SCANS);

`ifdef KEYPAD_RELEASE_EVENTS_EN
    localparam bit REL_EVT = 1'b1;
`else
    localparam bit REL_EVT = 1'b0;
`endif

    if (!scan_div_ok(SCAN_DIV, COLS)) begin : g_bad_scan_div
        $error("keypad_scanner: SCAN_DIV must be >= COLS+1 and >= 4");
    end
    if (!is_pow2(FIFO_DEPTH)) begin : g_bad_fifo_depth
        $error("keypad_scanner: FIFO_DEPTH must be a power of two");
    end

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v >= DEB_MAX) ? DEB_MAX : v + 1'b1;
    endfunction

    // ---------------------------------------------------------------
    // Input synchronisers. Columns idle high (pulled up); rows idle low
    // so nothing looks like contention straight out of reset.
    // ---------------------------------------------------------------
    logic [COLS-1:0] col_meta_q, col_sync_q;
    logic [ROWS-1:0] row_meta_q, row_sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_meta_q <= '1;
            col_sync_q <= '1;
            row_meta_q <= '0;
            row_sync_q <= '0;
        end else begin
            col_meta_q <= col_n;
            col_sync_q <= col_meta_q;
            row_meta_q <= row_in;
            row_sync_q <= row_meta_q;
        end
    end

    // ---------------------------------------------------------------
    // Scan counter. active_q holds row_oe at zero for exactly the reset
    // period; the slot counter only runs once a row is being driven.
    // ---------------------------------------------------------------
    logic             active_q, active_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [RW-1:0]    row_q, row_d;
    logic             slot_end;

    always_comb begin
        active_d = 1'b1;
        div_d    = div_q;
        row_d    = row_q;
        slot_end = active_q && (div_q == DIV_LAST);
        if (active_q) begin
            if (slot_end) begin
                div_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                div_d = div_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            div_q    <= '0;
            row_q    <= '0;
        end else begin
            active_q <= active_d;
            div_q    <= div_d;
            row_q    <= row_d;
        end
    end

    always_comb begin
        row_oe = '0;
        if (active_q) begin
            row_oe[row_q] = 1'b1;
        end
    end

    // ---------------------------------------------------------------
    // Slot sample. The column snapshot taken on the last cycle of a slot
    // is held through the following slot while its keys are evaluated.
    // ---------------------------------------------------------------
    logic [COLS-1:0] samp_q, samp_d;
    logic [RW-1:0]   samp_row_q, samp_row_d;

    always_comb begin
        samp_d     = samp_q;
        samp_row_d = samp_row_q;
        if (slot_end) begin
            samp_d     = col_sync_q;
            samp_row_d = row_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_q     <= '1;
            samp_row_q <= '0;
        end else begin
            samp_q     <= samp_d;
            samp_row_q <= samp_row_d;
        end
    end

    // ---------------------------------------------------------------
    // Debounce array. One key per cycle: column c of the held sample is
    // evaluated on slot cycle c+1, so each key touches its state alone.
    // ---------------------------------------------------------------
    logic [KEYS-1:0]            commit_q, commit_d;
    logic [KEYS-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic                       eval_en;
    logic [CW-1:0]              eval_col;
    logic [KW-1:0]              key_idx;
    logic                       raw_press;
    logic                       cur_commit;
    logic [CNT_W-1:0]           nxt_cnt;
    logic                       can_push;
    logic                       push;
    keypad_evt_t                push_evt;
    logic [EW-1:0]              push_code;
    logic                       fifo_full;
    logic                       fifo_empty;

    assign eval_en   = active_q && (div_q >= EVAL_FIRST) && (div_q <= EVAL_LAST);
    assign eval_col  = CW'(div_q - 1'b1);
    assign key_idx   = KW'(int'(samp_row_q) * COLS + int'(eval_col));
    assign raw_press = ~samp_q[eval_col];

    // A pop in this cycle frees a slot even when the FIFO reads full.
    assign can_push  = !fifo_full || (evt_valid && evt_ready);

    always_comb begin
        commit_d   = commit_q;
        cnt_d      = cnt_q;
        push       = 1'b0;
        cur_commit = commit_q[key_idx];
        nxt_cnt    = sat_inc(cnt_q[key_idx]);
        if (eval_en) begin
            if (raw_press == cur_commit) begin
                cnt_d[key_idx] = '0;
            end else begin
                cnt_d[key_idx] = nxt_cnt;
                if (nxt_cnt == DEB_MAX) begin
                    if (raw_press || REL_EVT) begin
                        // No room: leave the counter saturated and retry
                        // on this key's next sample.
                        if (can_push) begin
                            push              = 1'b1;
                            commit_d[key_idx] = raw_press;
                            cnt_d[key_idx]    = '0;
                        end
                    end else begin
                        commit_d[key_idx] = raw_press;
                        cnt_d[key_idx]    = '0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            commit_q <= '0;
            cnt_q    <= '0;
        end else begin
            commit_q <= commit_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        push_evt.press = raw_press;
        push_evt.row   = EVT_ROW_W'(samp_row_q);
        push_evt.col   = EVT_COL_W'(eval_col);
        // Row/column always fit their RW/CW fields, so truncation is exact.
        push_code = EW'((32'(push_evt.press) << (RW + CW))
                      | (32'(push_evt.row) << CW)
                      | 32'(push_evt.col));
    end

    // ---------------------------------------------------------------
    // Event FIFO
    // ---------------------------------------------------------------
    keypad_evt_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_evt_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (push),
        .wr_data (push_code),
        .full    (fifo_full),
        .rd_en   (evt_ready),
        .rd_data (evt_code),
        .empty   (fifo_empty)
    );

    assign evt_valid = !fifo_empty;

    // ---------------------------------------------------------------
    // Contention check. The first two slot cycles are skipped so the
    // synchronised readback reflects the row now being driven.
    // ---------------------------------------------------------------
    logic error_q, error_d;
    logic err_set;

    assign err_set = active_q && (div_q >= CHK_FIRST) && row_sync_q[row_q];

    always_comb begin
        error_d = error_q;
        if (err_set) begin
            error_d = 1'b1;
        end else if (err_clr) begin
            error_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            error_q <= 1'b0;
        end else begin
            error_q <= error_d;
        end
    end

    assign error = error_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a physical keypad model drives col_n from row_oe,
// a scoreboard queue collects the events each key change should produce, and
// a monitor pops and compares on every accepted event.
module tb_keypad_scanner;

    localparam int ROWS     = 4;
    localparam int COLS     = 3;
    localparam int SCAN_DIV = 8;
    localparam int DEB      = 4;
    localparam int DEPTH    = 4;
    localparam int FRAME    = ROWS * SCAN_DIV;
    localparam int EW       = 5;
    localparam int LAT_MAX  = (DEB + 1) * FRAME + COLS + 3;
    localparam int LAT_MIN  = (DEB - 1) * FRAME;

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic [ROWS-1:0]            row_oe;
    logic [ROWS-1:0]            row_in;
    logic [COLS-1:0]            col_n;
    logic                       evt_valid;
    logic                       evt_ready;
    logic [EW-1:0]              evt_code;
    logic                       error;
    logic                       err_clr;

    logic [ROWS-1:0][COLS-1:0]  pressed;
    logic                       fault;
    logic [EW-1:0]              sb_q [$];
    logic [EW-1:0]              exp_evt;
    int                         n_checks = 0;
    int                         n_fail   = 0;

    keypad_scanner #(
        .ROWS           (ROWS),
        .COLS           (COLS),
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DEB),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .row_oe    (row_oe),
        .row_in    (row_in),
        .col_n     (col_n),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_code  (evt_code),
        .error     (error),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    // Keypad: a pressed key shorts its column to the driven (low) row.
    always_comb begin
        col_n = '1;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (row_oe[r] && pressed[r][c]) col_n[c] = 1'b0;
            end
        end
    end

    // Undriven rows float high; a fault holds every row pin high.
    assign row_in = fault ? '1 : ~row_oe;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [EW-1:0] mk_evt(input bit p, input int r, input int c);
        return {p, 2'(r), 2'(c)};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_key(input int r, input int c, input bit v);
        pressed[r][c] = v;
        if (v) begin
            sb_q.push_back(mk_evt(1'b1, r, c));
        end else begin
`ifdef KEYPAD_RELEASE_EVENTS_EN
            sb_q.push_back(mk_evt(1'b0, r, c));
`endif
        end
    endtask

    // Leave the bench just after the edge that starts slot cycle 0.
    task automatic align_slot();
        logic [ROWS-1:0] prev;
        int n;
        prev = row_oe;
        n = 0;
        do begin
            tick(1);
            n++;
        end while (row_oe == prev && n < 20);
        chk("align_slot", 32'(n < 20), 1);
    endtask

    always @(negedge clk) begin
        if (rst_n && evt_valid && evt_ready) begin
            chk("evt_expected", 32'(sb_q.size() != 0), 1);
            if (sb_q.size() != 0) begin
                exp_evt = sb_q.pop_front();
                chk("evt_code", 32'(evt_code), 32'(exp_evt));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int kr [6];
        int kc [6];
        int lat;
        kr = '{0, 1, 2, 1, 3, 3};
        kc = '{0, 1, 2, 0, 0, 1};

        pressed   = '0;
        fault     = 1'b0;
        evt_ready = 1'b1;
        err_clr   = 1'b0;
        rst_n     = 1'b0;
        tick(3);

        // Reset state
        chk("rst_row_oe", 32'(row_oe), 0);
        chk("rst_evt_valid", 32'(evt_valid), 0);
        chk("rst_evt_code", 32'(evt_code), 0);
        chk("rst_error", 32'(error), 0);

        // Idle scan: row 0 on the first cycle, one row per SCAN_DIV clocks
        rst_n = 1'b1;
        tick(1);
        for (int k = 0; k < 40; k++) begin
            chk("scan_row_oe", 32'(row_oe), 32'(1) << ((k / SCAN_DIV) % ROWS));
            tick(1);
        end
        chk("idle_evt_valid", 32'(evt_valid), 0);
        chk("idle_error", 32'(error), 0);

        // Single press with latency bounds, then release
        set_key(2, 1, 1'b1);
        lat = 0;
        while (!evt_valid && lat < 2 * LAT_MAX) begin
            tick(1);
            lat++;
        end
        chk("press_seen", 32'(evt_valid), 1);
        chk("press_lat_max", 32'(lat <= LAT_MAX), 1);
        chk("press_lat_min", 32'(lat >= LAT_MIN), 1);
        tick(10 * FRAME - lat);
        chk("press_sb_empty", 32'(sb_q.size()), 0);
        set_key(2, 1, 1'b0);
        tick(10 * FRAME);
        chk("release_sb_empty", 32'(sb_q.size()), 0);
        chk("release_quiet", 32'(evt_valid), 0);

        // Bounce: toggle (0,0) every 2 frames, ending released
        for (int i = 0; i < 6; i++) begin
            pressed[0][0] = ~pressed[0][0];
            tick(2 * FRAME);
        end
        tick(6 * FRAME);
        chk("bounce_quiet", 32'(evt_valid), 0);

        // Backpressure: 6 presses while stalled, 2 must wait for space
        evt_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            set_key(kr[i], kc[i], 1'b1);
            tick(6 * FRAME);
        end
        tick(2 * FRAME);
        chk("bp_valid_held", 32'(evt_valid), 1);
        chk("bp_sb_pending", 32'(sb_q.size()), 6);
        evt_ready = 1'b1;
        tick(3 * FRAME);
        chk("bp_drained", 32'(sb_q.size()), 0);
        for (int i = 0; i < 6; i++) begin
            set_key(kr[i], kc[i], 1'b0);
            tick(6 * FRAME);
        end
        chk("bp_release_drained", 32'(sb_q.size()), 0);
        chk("bp_quiet", 32'(evt_valid), 0);

        // Contention flag
        chk("err_idle", 32'(error), 0);
        fault = 1'b1;
        tick(FRAME + 4);
        chk("err_set", 32'(error), 1);
        fault = 1'b0;
        tick(FRAME);
        chk("err_sticky", 32'(error), 1);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("err_clr_ok", 32'(error), 0);
        tick(FRAME);
        chk("err_stays_clear", 32'(error), 0);
        fault = 1'b1;
        tick(FRAME);
        chk("err_reset_again", 32'(error), 1);
        align_slot();
        tick(4);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("err_set_beats_clr", 32'(error), 1);
        fault = 1'b0;
        tick(FRAME);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;

        // Reset mid-frame with two queued events
        evt_ready = 1'b0;
        set_key(0, 2, 1'b1);
        tick(6 * FRAME);
        set_key(1, 2, 1'b1);
        tick(6 * FRAME);
        chk("rst_pre_valid", 32'(evt_valid), 1);
        chk("rst_pre_pending", 32'(sb_q.size()), 2);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", 32'(evt_valid), 0);
        chk("rst_mid_row_oe", 32'(row_oe), 0);
        chk("rst_mid_code", 32'(evt_code), 0);
        sb_q.delete();
        pressed   = '0;
        evt_ready = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        chk("rst_restart_row0", 32'(row_oe), 1);
        tick(SCAN_DIV);
        chk("rst_restart_row1", 32'(row_oe), 2);
        tick(8 * FRAME);
        chk("rst_no_evt", 32'(evt_valid), 0);
        chk("rst_error_clear", 32'(error), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
